// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between an async FIFO and the UART transmitter
// that drains it. The consumer (master) issues pops; the FIFO (slave) answers.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             empty;
  logic [WIDTH-1:0] rdata;
  logic             rinc;

  modport master (
    input  empty,
    input  rdata,
    output rinc
  );

  modport slave (
    output empty,
    output rdata,
    input  rinc
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops words from an async FIFO read port and serialises each one as a UART frame
// (start, WIDTH data bits LSB first, optional parity, one stop), back-to-back.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master fifo,
  input  logic           par_en,
  input  logic           par_typ,
  output logic           tx_out,
  output logic           busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             tx_q, tx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             pen_q, pen_d;
  logic             pbit_q, pbit_d;
  logic             last_cyc;
  logic             fetch;

  assign last_cyc = (cyc_q == CNT_LAST);
  // The FIFO is only looked at when idle or at the very end of a stop bit.
  assign fetch = !rst && !fifo.empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && last_cyc));

  assign fifo.rinc = fetch;
  assign busy      = (state_q != IDLE);
  assign tx_out    = tx_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pen_d   = pen_q;
    pbit_d  = pbit_q;
    tx_d    = 1'b1;

    case (state_q)
      IDLE:   if (fetch) state_d = START;
      START:  if (last_cyc) state_d = DATA;
      DATA: begin
        if (last_cyc) begin
          if (bit_q == BIT_LAST) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: if (last_cyc) state_d = STOP;
      STOP:   if (last_cyc) state_d = fetch ? START : IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cyc_d = '0;
      bit_d = '0;
    end else if (state_q != IDLE) begin
      cyc_d = last_cyc ? '0 : cyc_q + CNT_W'(1);
    end

    // Frame settings are frozen at the pop so mid-frame changes are ignored.
    if (fetch) begin
      shift_d = fifo.rdata;
      pen_d   = par_en;
      pbit_d  = (^fifo.rdata) ^ par_typ;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = pbit_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    pen_q   <= pen_d;
    pbit_q  <= pbit_d;
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 and 1 clocks per bit) fed by small FIFO
// models, with frame monitors checking tx_out against a queue of expected frames.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, par_en, par_typ;
  logic tx4, busy4, tx1, busy1;

  fifo_uart_tx_if #(.WIDTH(8)) if4 ();
  fifo_uart_tx_if #(.WIDTH(8)) if1 ();

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .fifo(if4), .par_en(par_en), .par_typ(par_typ),
    .tx_out(tx4), .busy(busy4)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .fifo(if1), .par_en(par_en), .par_typ(par_typ),
    .tx_out(tx1), .busy(busy1)
  );

  // FIFO models: written by the stimulus, popped by the DUT's rinc.
  logic [7:0] mem4 [0:15];
  logic [7:0] mem1 [0:15];
  int wr4 = 0, rd4 = 0, wr1 = 0, rd1 = 0;

  assign if4.empty = (wr4 == rd4);
  assign if4.rdata = mem4[rd4[3:0]];
  assign if1.empty = (wr1 == rd1);
  assign if1.rdata = mem1[rd1[3:0]];

  always @(posedge clk) if (if4.rinc) rd4 <= rd4 + 1;
  always @(posedge clk) if (if1.rinc) rd1 <= rd1 + 1;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
  } frame_t;

  frame_t exp4[$];
  frame_t exp1[$];
  int n_cmp = 0, n_err = 0, frames4 = 0, frames1 = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, act, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] w, input logic pen, input logic ptyp);
    frame_t f;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = w[i];
    if (pen) f.bits[9] = (^w) ^ ptyp;
    f.nbits = pen ? 11 : 10;
    return f;
  endfunction

  task automatic push4(input logic [7:0] w);
    exp4.push_back(make_frame(w, par_en, par_typ));
    mem4[wr4[3:0]] = w;
    wr4 = wr4 + 1;
  endtask

  task automatic push1(input logic [7:0] w);
    exp1.push_back(make_frame(w, par_en, par_typ));
    mem1[wr1[3:0]] = w;
    wr1 = wr1 + 1;
  endtask

  initial begin : mon4
    frame_t cur;
    int c;
    bit inf;
    inf = 0;
    c = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inf = 0;
      end else begin
        if (!inf && tx4 == 1'b0) begin
          if (exp4.size() == 0) check_val("mon4_expected_frames", exp4.size(), 1);
          else begin
            cur = exp4.pop_front();
            inf = 1;
            c = 0;
          end
        end
        if (inf) begin
          check_val("tx4_bit", tx4, cur.bits[c/4]);
          check_val("busy4_in_frame", busy4, 1);
          c++;
          if (c == cur.nbits * 4) begin
            inf = 0;
            frames4++;
          end
        end
      end
    end
  end

  initial begin : mon1
    frame_t cur;
    int c;
    bit inf;
    inf = 0;
    c = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inf = 0;
      end else begin
        if (!inf && tx1 == 1'b0) begin
          if (exp1.size() == 0) check_val("mon1_expected_frames", exp1.size(), 1);
          else begin
            cur = exp1.pop_front();
            inf = 1;
            c = 0;
          end
        end
        if (inf) begin
          check_val("tx1_bit", tx1, cur.bits[c]);
          check_val("busy1_in_frame", busy1, 1);
          c++;
          if (c == cur.nbits) begin
            inf = 0;
            frames1++;
          end
        end
      end
    end
  end

  // Follows one frame cycle by cycle from the fetch cycle; optionally flips par_typ mid-frame.
  task automatic watch_frame(input int len, input int tog);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      check_val("busy4_window", busy4, (k <= len));
      check_val("rinc4_quiet", if4.rinc, 0);
      if (k == tog) par_typ = ~par_typ;
    end
  endtask

  task automatic run_frame(input logic [7:0] w, input logic pen, input logic ptyp, input int tog);
    par_en  = pen;
    par_typ = ptyp;
    push4(w);
    #1;
    check_val("rinc4_fetch", if4.rinc, 1);
    watch_frame((10 + int'(pen)) * 4, tog);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    par_en  = 1'b0;
    par_typ = 1'b0;

    // Reset held for three edges, then an empty FIFO for 50 cycles.
    for (int i = 0; i < 53; i++) begin
      @(negedge clk);
      check_val("idle_tx4", tx4, 1);
      check_val("idle_busy4", busy4, 0);
      check_val("idle_rinc4", if4.rinc, 0);
      check_val("idle_tx1", tx1, 1);
      check_val("idle_busy1", busy1, 0);
      if (i == 2) rst = 1'b0;
    end

    run_frame(8'hA5, 1'b0, 1'b0, 0);
    check_val("frames_after_a5", frames4, 1);

    run_frame(8'h07, 1'b1, 1'b0, 20);
    run_frame(8'h07, 1'b1, 1'b1, 20);
    check_val("frames_after_parity", frames4, 3);

    // Two words queued at once: second frame starts right after the first stop bit.
    par_en = 1'b0;
    push4(8'h3C);
    push4(8'hC3);
    #1;
    check_val("b2b_rinc_first", if4.rinc, 1);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      check_val("b2b_busy", busy4, (k <= 80));
      check_val("b2b_rinc", if4.rinc, (k == 40));
    end
    check_val("frames_after_b2b", frames4, 5);

    // Reset in the middle of data bit 3 of 0xFF.
    push4(8'hFF);
    #1;
    check_val("rst_rinc_fetch", if4.rinc, 1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      check_val("rst_busy_before", busy4, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_tx4", tx4, 1);
    check_val("rst_busy4", busy4, 0);
    check_val("rst_rinc4", if4.rinc, 0);
    push4(8'h5A);
    #1;
    check_val("rst_rinc_gated", if4.rinc, 0);
    @(negedge clk);
    check_val("rst_tx4_hold", tx4, 1);
    check_val("rst_busy4_hold", busy4, 0);
    check_val("rst_rinc4_hold", if4.rinc, 0);
    rst = 1'b0;
    #1;
    check_val("post_rst_rinc", if4.rinc, 1);
    watch_frame(40, 0);
    check_val("frames_after_reset", frames4, 6);

    // One clock per bit.
    par_en = 1'b0;
    push1(8'h80);
    #1;
    check_val("rinc1_fetch", if1.rinc, 1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check_val("busy1_window", busy1, (k <= 10));
      check_val("rinc1_quiet", if1.rinc, 0);
    end
    check_val("frames1", frames1, 1);

    check_val("fifo4_pops", rd4, wr4);
    check_val("fifo1_pops", rd1, wr1);
    check_val("exp4_drained", exp4.size(), 0);
    check_val("exp1_drained", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
